// File: rtl/cordic_sincos_ctrl.sv
// cordic_sincos_ctrl: folds a full-circle phase into CORDIC range, sequences the core, returns quadrant-corrected saturated cos/sin
module cordic_sincos_ctrl #(
  parameter logic [15:0] AMPLITUDE = 16'd19898,
  parameter int          TIMEOUT   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_phase,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_cos,
  output logic [15:0] res_sin,
  output logic        err_timeout,
  output logic        core_start,
  output logic [15:0] core_angle,
  output logic [15:0] core_x,
  output logic [15:0] core_y,
  input  logic [16:0] core_cos,
  input  logic [16:0] core_sin,
  input  logic        core_done,
  input  logic        core_busy
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t          state_q, state_d;
  logic [15:0]     angle_q, angle_d, cos_q, cos_d, sin_q, sin_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d, err_q, err_d;
  logic            out_range;
  // Negate when the phase was folded by 180 deg, then clamp symmetric so -32768 never appears
  function automatic logic [15:0] fix(input logic [16:0] v, input logic n);
    logic signed [17:0] w;
    w = n ? -$signed({v[16], v}) : $signed({v[16], v});
    return (w > 18'sd32767) ? 16'h7fff : (w < -18'sd32767) ? 16'h8001 : w[15:0];
  endfunction
  assign out_range   = req_phase[15] ^ req_phase[14];
  assign req_ready   = state_q == IDLE;
  assign res_valid   = state_q == HOLD;
  assign res_cos     = cos_q;
  assign res_sin     = sin_q;
  assign err_timeout = err_q;
  assign core_angle  = angle_q;
  assign core_x      = AMPLITUDE;
  assign core_y      = 16'd0;
  // Next-state, capture and correction logic for the request/launch/wait/hold sequence
  always_comb begin
    state_d    = state_q;
    angle_d    = angle_q;
    neg_d      = neg_q;
    cnt_d      = cnt_q;
    cos_d      = cos_q;
    sin_d      = sin_q;
    err_d      = err_q;
    core_start = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        angle_d = out_range ? {~req_phase[15], req_phase[14:0]} : req_phase;
        neg_d   = out_range;
        state_d = LAUNCH;
      end
      LAUNCH: if (!core_busy) begin
        core_start = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (core_done) begin
          cos_d   = fix(core_cos, neg_q);
          sin_d   = fix(core_sin, neg_q);
          state_d = HOLD;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      angle_q <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_cordic_sincos_ctrl.sv
// tb_cordic_sincos_ctrl: directed tests of the CORDIC front-end sequencer against a scripted core model
module tb_cordic_sincos_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, res_ready = 0, core_busy = 0, stray = 0;
  logic [15:0] req_phase = 0;
  logic        req_ready, res_valid, err_timeout, core_start;
  logic [15:0] res_cos, res_sin, core_angle, core_x, core_y;
  logic [16:0] core_cos, core_sin;
  logic        core_done_m, core_done;
  logic [16:0] mdl_cos = 0, mdl_sin = 0;
  logic        mdl_en = 1;
  int          core_cnt, starts, errors = 0, checks = 0;

  cordic_sincos_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_phase(req_phase), .res_valid(res_valid), .res_ready(res_ready),
    .res_cos(res_cos), .res_sin(res_sin), .err_timeout(err_timeout),
    .core_start(core_start), .core_angle(core_angle), .core_x(core_x), .core_y(core_y),
    .core_cos(core_cos), .core_sin(core_sin), .core_done(core_done), .core_busy(core_busy)
  );

  always #5 clk = ~clk;
  assign core_cos  = mdl_cos;
  assign core_sin  = mdl_sin;
  assign core_done = core_done_m | stray;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_cnt    <= 0;
      core_done_m <= 0;
    end else begin
      core_done_m <= 0;
      if (core_start && mdl_en) core_cnt <= 16;
      else if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) core_done_m <= 1;
      end
    end
  end

  always @(negedge clk) if (core_start) starts++;

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if ({res_cos, res_sin, core_angle} !== 48'd0) begin errors++; $display("FAIL reset_data got=%h %h %h exp=0", res_cos, res_sin, core_angle); end
    checks++; if ({err_timeout, core_start} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", err_timeout, core_start); end
    checks++; if (core_x !== 16'd19898 || core_y !== 16'd0) begin errors++; $display("FAIL core_xy got=%0d %0d exp=19898 0", core_x, core_y); end
  endtask

  task automatic test_vector(input string nm, input logic [15:0] ph, input int cc, input int cs,
                             input logic [15:0] ea, input int ec, input int es);
    bit got;
    mdl_cos = 17'(cc); mdl_sin = 17'(cs);
    @(negedge clk);
    starts = 0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got=%b exp=1", nm, req_ready); end
    req_valid = 1; req_phase = ph;
    @(negedge clk);
    req_valid = 0;
    checks++; if (core_angle !== ea) begin errors++; $display("FAIL %s_angle got=%h exp=%h", nm, core_angle, ea); end
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = res_valid;
    end
    checks++; if (!got) begin errors++; $display("FAIL %s_timeout got=no_res_valid exp=res_valid", nm); end
    checks++; if (res_cos !== 16'(ec)) begin errors++; $display("FAIL %s_cos got=%0d exp=%0d", nm, $signed(res_cos), ec); end
    checks++; if (res_sin !== 16'(es)) begin errors++; $display("FAIL %s_sin got=%0d exp=%0d", nm, $signed(res_sin), es); end
    checks++; if (starts !== 1) begin errors++; $display("FAIL %s_starts got=%0d exp=1", nm, starts); end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL %s_release got=%b%b exp=01", nm, res_valid, req_ready); end
  endtask

  task automatic test_busy_stall();
    bit got;
    core_busy = 1; mdl_cos = 17'd1000; mdl_sin = 17'd2000;
    @(negedge clk);
    starts = 0;
    req_valid = 1; req_phase = 16'h0100;
    @(negedge clk);
    req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (core_start !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL busy_hold got=%b%b exp=00", core_start, req_ready); end
      @(negedge clk);
    end
    core_busy = 0;
    #1;
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL busy_release got=%b exp=1", core_start); end
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = res_valid;
    end
    checks++; if (!got || res_cos !== 16'd1000 || res_sin !== 16'd2000 || starts !== 1) begin errors++; $display("FAIL busy_result got=%b %0d %0d %0d exp=1 1000 2000 1", got, res_cos, res_sin, starts); end
    res_ready = 1; @(negedge clk); res_ready = 0;
  endtask

  task automatic test_stray_done();
    @(negedge clk);
    stray = 1;
    @(negedge clk);
    stray = 0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stray_done got=%b%b exp=01", res_valid, req_ready); end
  endtask

  task automatic test_hold();
    bit got;
    mdl_cos = 17'd12345; mdl_sin = -17'sd2222;
    @(negedge clk);
    starts = 0;
    req_valid = 1; req_phase = 16'h0800;
    @(negedge clk);
    req_phase = 16'h4000;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = res_valid;
    end
    checks++; if (!got) begin errors++; $display("FAIL hold_valid got=0 exp=1"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_cos !== 16'd12345 || res_sin !== 16'hf752) begin
        errors++; $display("FAIL hold_stable got=%b%b %0d %h exp=10 12345 f752", res_valid, req_ready, res_cos, res_sin); end
    end
    res_ready = 1; req_valid = 0;
    @(negedge clk);
    res_ready = 0;
    @(negedge clk);
    checks++; if (starts !== 1 || req_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL hold_exit got=%0d %b%b exp=1 10", starts, req_ready, res_valid); end
    test_vector("after_hold", 16'h2000, 23170, 23170, 16'h2000, 23170, 23170);
  endtask

  task automatic test_timeout();
    mdl_en = 0;
    @(negedge clk);
    req_valid = 1; req_phase = 16'h0040;
    @(negedge clk);
    req_valid = 0;
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL to_start got=%b exp=1", core_start); end
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if (res_valid) begin checks++; errors++; $display("FAIL to_res_valid got=1 exp=0 cycle=%0d", n); end
      if (n == 32) begin checks++; if (err_timeout !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL to_early got=%b%b exp=00", err_timeout, req_ready); end end
      if (n == 33) begin checks++; if (err_timeout !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL to_fire got=%b%b exp=11", err_timeout, req_ready); end end
    end
    repeat (3) @(negedge clk);
    checks++; if (err_timeout !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL to_sticky got=%b%b exp=10", err_timeout, res_valid); end
  endtask

  task automatic test_reset_mid_wait();
    mdl_en = 0;
    @(negedge clk);
    req_valid = 1; req_phase = 16'h7000;
    @(negedge clk);
    req_valid = 0;
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0 || err_timeout !== 1'b0 || core_start !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags got=%b%b%b%b exp=1000", req_ready, res_valid, err_timeout, core_start); end
    checks++; if ({res_cos, res_sin, core_angle} !== 48'd0) begin errors++; $display("FAIL rst_mid_data got=%h %h %h exp=0", res_cos, res_sin, core_angle); end
    @(negedge clk);
    rst_n = 1; mdl_en = 1;
    test_vector("post_rst", 16'h0000, 32000, 100, 16'h0000, 32000, 100);
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1;
    test_vector("zero",    16'h0000, 32768, 5,      16'h0000, 32767, 5);
    test_vector("p90",     16'h4000, 3,     -32766, 16'hc000, -3,    32766);
    test_vector("p180",    16'h8000, 32768, -2,     16'h0000, -32767, 2);
    test_vector("p135",    16'h6000, 23170, -23170, 16'he000, -23170, 23170);
    test_vector("clamp",   16'h1000, -33000, 40000, 16'h1000, -32767, 32767);
    test_vector("m90",     16'hc000, 4,     -32767, 16'hc000, 4,     -32767);
    test_vector("edge_hi", 16'h3fff, 100,   32767,  16'h3fff, 100,   32767);
    test_vector("neg_big", 16'ha000, -65536, 65535, 16'h2000, 32767, -32767);
    test_busy_stall();
    test_stray_done();
    test_hold();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cordic_sincos_ctrl.md
Name: cordic_sincos_ctrl

Overview:
Front-end sequencer for the vectoring/rotation CORDIC core in the 3D transform path. It accepts a full-circle 16-bit phase over a valid/ready handshake and folds it into the core's convergence range (±90°). It then launches the core with a gain-compensated start vector, waits for completion, and applies the quadrant correction. The result is returned as saturated Q1.15 cos/sin over a valid/ready handshake to the rotation-matrix builder.

Parameters:
AMPLITUDE, 19898, core x_in start value (0.60725·2^15, cancels CORDIC gain); core y_in fixed 0
TIMEOUT, 32, max cycles in WAIT before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  phase request valid
req_ready  out  1  block can accept a request
req_phase  in  16  phase, 65536 = 360°, read as signed (0x4000 = +90°, 0x8000 = ±180°)
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_cos  out  16  signed Q1.15 cosine
res_sin  out  16  signed Q1.15 sine
err_timeout  out  1  sticky; core failed to signal done within TIMEOUT
core_start  out  1  one-cycle start pulse to core
core_angle  out  16  folded angle to core
core_x  out  16  constant AMPLITUDE
core_y  out  16  constant 0
core_cos  in  17  core x result
core_sin  in  17  core y result
core_done  in  1  core completion pulse
core_busy  in  1  core busy

Behaviour:
- Reset values (async, rst_n low): state IDLE, req_ready 1, res_valid 0, res_cos/res_sin 0, err_timeout 0, core_start 0, core_angle 0, neg flag 0, timeout counter 0.
- Fold rule for signed phase a:
  - If -16384 ≤ a ≤ 16383: angle = a, neg = 0.
  - Otherwise: angle = a with MSB inverted (a+180° mod 2^16, lands in [-16384,16383]), neg = 1.
- core_angle comes from a register and holds constant from capture until the next capture. core_x and core_y are constants.
- FSM:
  - IDLE: req_ready = 1. On req_valid & req_ready, register the folded angle and neg, then go to LAUNCH.
  - LAUNCH: req_ready = 0. If core_busy = 1, stay and hold core_start = 0. Otherwise assert core_start = 1 for exactly this cycle, clear the timeout counter, and go to WAIT.
  - WAIT: increment the timeout counter each cycle.
    - On core_done = 1: register corrected results, set res_valid = 1, go to HOLD.
    - Else if counter reaches TIMEOUT: set err_timeout = 1, go to IDLE with no result emitted.
  - HOLD: res_valid = 1 and res_cos/res_sin stable until res_ready = 1. Then res_valid = 0 next cycle and go to IDLE.
  - req_ready stays 0 in HOLD; a request is never accepted in the same cycle a result is consumed.
- Correction arithmetic, per channel, on 17-bit signed v:
  - w = neg ? -v : v, computed in 18 bits.
  - Clamp w to [-32767, +32767], then truncate to 16 bits.
  - -32768 is never emitted.
- Latency: request accept → LAUNCH +1 → start +1 → core done (~16 cycles) → res_valid on the cycle after core_done.
- core_done seen in any state other than WAIT is ignored.
- err_timeout is cleared only by reset.
- Reset mid-operation (any state): return to IDLE immediately and drop any pending result. The core shares rst_n.
- One request in flight at most. No pipelining.

Test Plan:
- req_phase 0x0000 → core_angle 0x0000, neg 0; res_cos 32767 ±8, res_sin 0 ±8; exactly one core_start pulse.
- req_phase 0x4000 (+90°) → core_angle 0x4000, neg 1 folds to 0xC000? No: 0x4000 = 16384 is out of range, so core_angle 0xC000, neg 1; res_cos 0 ±8, res_sin +32767 ±8.
- req_phase 0x8000 (180°) → core_angle 0x0000, neg 1; res_cos -32767 ±8, res_sin 0 ±8. Core value +32768 must saturate to -32767 after negation.
- req_phase 0x6000 (135°) → core_angle 0xE000 (-45°), neg 1; res_cos -23170 ±8, res_sin +23170 ±8.
- res_ready held low 10 cycles after res_valid → res_cos/res_sin stable, req_ready 0, new req_valid ignored. Raising res_ready returns to IDLE; next request is accepted normally.
- Core model never asserts done → err_timeout rises 32 cycles after core_start, no res_valid, state back to IDLE. A separate case pulls rst_n low mid-WAIT: all outputs return to reset values.
